// File: rtl/cpu_axi_bridge.sv
// Bridges the bit_mips ibus/dbus request ports onto a single-beat AXI master,
// one outstanding transaction at a time, with dbus given priority over ibus.
module cpu_axi_bridge #(
  parameter int ID_W       = 4,
  parameter int KSEG_XLATE = 1
) (
  input  logic              clock,
  input  logic              reset,

  input  logic [31:0]       ibus_addr,
  input  logic              ibus_read,
  output logic [31:0]       ibus_data,
  output logic              ibus_stall,

  input  logic [31:0]       dbus_addr,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [31:0]       dbus_wdata,
  input  logic [3:0]        dbus_byteenable,
  output logic [31:0]       dbus_data,
  output logic              dbus_stall,

  input  logic [4:0]        cpu_stall,
  input  logic              cpu_flush,

  output logic [ID_W-1:0]   arid,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic              rvalid,
  input  logic              rlast,
  output logic              rready,

  output logic [ID_W-1:0]   awid,
  output logic [31:0]       awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  logic [2:0]  state;
  logic        src;        // 0 = ibus owns the transaction, 1 = dbus
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done;
  logic        w_done;
  logic        discard;
  logic        i_valid;
  logic        d_valid;
  logic [31:0] i_buf;
  logic [31:0] d_buf;

  logic        d_req;
  logic        d_pend;
  logic        i_pend;
  logic        r_hs;
  logic        b_hs;
  logic        keep;

  // kseg0/kseg1 both alias the low 512 MB of physical space.
  function automatic logic [31:0] xlate(input logic [31:0] a);
    if (KSEG_XLATE != 0 && a[31:30] == 2'b10) return {3'b000, a[28:0]};
    return a;
  endfunction

  assign d_req  = dbus_read | dbus_write;
  assign d_pend = d_req & ~d_valid & ~cpu_flush;
  assign i_pend = ibus_read & ~i_valid & ~cpu_flush;

  assign ibus_stall = ibus_read & ~i_valid;
  assign dbus_stall = d_req & ~d_valid;

  assign r_hs = (state == RD_DATA) & rvalid;
  assign b_hs = (state == WR_RESP) & bvalid;
  // A flush on the completing edge drops the result just like a latched discard.
  assign keep = ~discard & ~cpu_flush;

  assign arid    = '0;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = (state == RD_ADDR);
  assign rready  = (state == RD_DATA);

  assign awid    = '0;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awvalid = (state == WR_REQ) & ~aw_done;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (state == WR_REQ) & ~w_done;
  assign bready  = (state == WR_RESP);

  assign ibus_data = i_buf;
  assign dbus_data = d_buf;

  logic unused_inputs;
  assign unused_inputs = ^{rlast, cpu_stall[3:2], cpu_stall[0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      src     <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_pend) begin
            src     <= 1'b1;
            addr_q  <= xlate(dbus_addr);
            wdata_q <= dbus_wdata;
            wstrb_q <= dbus_byteenable;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= dbus_write ? WR_REQ : RD_ADDR;
          end else if (i_pend) begin
            src    <= 1'b0;
            addr_q <= xlate(ibus_addr);
            state  <= RD_ADDR;
          end
        end
        RD_ADDR: if (arready) state <= RD_DATA;
        RD_DATA: if (rvalid) state <= IDLE;
        WR_REQ: begin
          if (awready) aw_done <= 1'b1;
          if (wready)  w_done  <= 1'b1;
          if ((aw_done | awready) & (w_done | wready)) state <= WR_RESP;
        end
        WR_RESP: if (bvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              discard <= 1'b0;
    else if (r_hs | b_hs)                   discard <= 1'b0;
    else if (cpu_flush && state != IDLE)    discard <= 1'b1;
  end

  // Set only happens while the stage is stalled, so set/retire never collide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       i_valid <= 1'b0;
    else if (cpu_flush)              i_valid <= 1'b0;
    else if (r_hs & ~src & ~discard) i_valid <= 1'b1;
    else if (~cpu_stall[1])          i_valid <= 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  d_valid <= 1'b0;
    else if (cpu_flush)                         d_valid <= 1'b0;
    else if (((r_hs & src) | b_hs) & ~discard)  d_valid <= 1'b1;
    else if (~cpu_stall[4])                     d_valid <= 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_buf <= '0;
      d_buf <= '0;
    end else if (r_hs & keep) begin
      if (src) d_buf <= rdata;
      else     i_buf <= rdata;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: a table of single fetch/load vectors plus
// hand-written sequences for arbitration, split AW/W, flush, hold and reset.
module tb_cpu_axi_bridge;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ibus_addr = '0;
  logic        ibus_read = 1'b0;
  logic [31:0] ibus_data;
  logic        ibus_stall;
  logic [31:0] dbus_addr = '0;
  logic        dbus_read = 1'b0;
  logic        dbus_write = 1'b0;
  logic [31:0] dbus_wdata = '0;
  logic [3:0]  dbus_byteenable = '0;
  logic [31:0] dbus_data;
  logic        dbus_stall;
  logic [4:0]  cpu_stall = '0;
  logic        cpu_flush = 1'b0;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [3:0]  wstrb;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic        rlast = 1'b0;
  logic        awready = 1'b0;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;

  int errors = 0;
  int checks = 0;

  cpu_axi_bridge dut (
    .clock(clock), .reset(reset),
    .ibus_addr(ibus_addr), .ibus_read(ibus_read), .ibus_data(ibus_data), .ibus_stall(ibus_stall),
    .dbus_addr(dbus_addr), .dbus_read(dbus_read), .dbus_write(dbus_write),
    .dbus_wdata(dbus_wdata), .dbus_byteenable(dbus_byteenable),
    .dbus_data(dbus_data), .dbus_stall(dbus_stall),
    .cpu_stall(cpu_stall), .cpu_flush(cpu_flush),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

  // AXI slave: each ready/valid response fires after a programmable number of
  // cycles of the matching valid/ready; read data is the address XOR KEY.
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] ar_log[$];
  logic [31:0] last_ar = '0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  always @(negedge clock) begin
    if (arvalid) begin
      arready = (ar_cnt == ar_dly);
      if (arready) begin ar_log.push_back(araddr); last_ar = araddr; ar_cnt = 0; end
      else ar_cnt++;
    end else begin arready = 1'b0; ar_cnt = 0; end
    if (rready) begin
      rvalid = (r_cnt == r_dly);
      rdata  = last_ar ^ KEY;
      rlast  = rvalid;
      if (rvalid) r_cnt = 0; else r_cnt++;
    end else begin rvalid = 1'b0; rlast = 1'b0; r_cnt = 0; end
    if (awvalid) begin
      awready = (aw_cnt == aw_dly);
      if (awready) begin cap_awaddr = awaddr; aw_cnt = 0; end else aw_cnt++;
    end else begin awready = 1'b0; aw_cnt = 0; end
    if (wvalid) begin
      wready = (w_cnt == w_dly);
      if (wready) begin cap_wdata = wdata; cap_wstrb = wstrb; w_cnt = 0; end else w_cnt++;
    end else begin wready = 1'b0; w_cnt = 0; end
    if (bready) begin
      bvalid = (b_cnt == b_dly);
      if (bvalid) b_cnt = 0; else b_cnt++;
    end else begin bvalid = 1'b0; b_cnt = 0; end
  end

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete read on either bus with a zero-wait slave, then retire it.
  task automatic run_read(input bit is_d, input logic [31:0] a, input logic [31:0] exp_a,
                          input int exp_n, input string tag);
    int n;
    cpu_stall = 5'h1f;
    if (is_d) begin dbus_read = 1'b1; dbus_addr = a; end
    else begin ibus_read = 1'b1; ibus_addr = a; end
    #1;
    n = 0;
    while ((is_d ? dbus_stall : ibus_stall) && n < 20) begin n++; tick(); end
    check({tag, " stall_cycles"}, 32'(n), 32'(exp_n));
    check({tag, " araddr"}, last_ar, exp_a);
    check({tag, " data"}, is_d ? dbus_data : ibus_data, exp_a ^ KEY);
    ibus_read = 1'b0; dbus_read = 1'b0; cpu_stall = 5'h00;
    tick();
    if (is_d) dbus_read = 1'b1; else ibus_read = 1'b1;
    #1;
    check({tag, " retired"}, 32'(is_d ? dbus_stall : ibus_stall), 32'd1);
    ibus_read = 1'b0; dbus_read = 1'b0;
    tick();
  endtask

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [31:0] exp_araddr;
    int          exp_stall;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, d_done, i_done;
    logic [15:0] aw_m, w_m, b_m, ar_m, r_m, st_m;
    logic [31:0] held;

    vecs[0] = '{1'b0, 32'hBFC0_0000, 32'h1FC0_0000, 3};
    vecs[1] = '{1'b1, 32'h8000_1234, 32'h0000_1234, 3};
    vecs[2] = '{1'b0, 32'h0040_0000, 32'h0040_0000, 3};
    vecs[3] = '{1'b1, 32'hC000_0010, 32'hC000_0010, 3};
    vecs[4] = '{1'b1, 32'hA000_0100, 32'h0000_0100, 3};

    tick(); tick();
    check("rst arvalid", 32'(arvalid), 32'd0);
    check("rst rready",  32'(rready),  32'd0);
    check("rst awvalid", 32'(awvalid), 32'd0);
    check("rst wvalid",  32'(wvalid),  32'd0);
    check("rst bready",  32'(bready),  32'd0);
    check("rst ibus_data", ibus_data, 32'h0);
    check("rst dbus_data", dbus_data, 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      run_read(vecs[i].is_d, vecs[i].addr, vecs[i].exp_araddr, vecs[i].exp_stall,
               $sformatf("vec%0d", i));

    // Simultaneous fetch and load: dbus must win arbitration.
    ar_log.delete();
    ibus_read = 1'b1; ibus_addr = 32'h8000_0010;
    dbus_read = 1'b1; dbus_addr = 32'h8000_1000;
    cpu_stall = 5'h1f;
    #1;
    d_done = -1; i_done = -1;
    for (int k = 0; k < 30; k++) begin
      if (!dbus_stall && d_done < 0) d_done = k;
      if (!ibus_stall && i_done < 0) i_done = k;
      if (d_done >= 0 && i_done >= 0) break;
      tick();
    end
    check("arb ar_count", 32'(ar_log.size()), 32'd2);
    check("arb first_ar",  (ar_log.size() > 0) ? ar_log[0] : 32'hx, 32'h0000_1000);
    check("arb second_ar", (ar_log.size() > 1) ? ar_log[1] : 32'hx, 32'h0000_0010);
    check("arb dbus_done", 32'(d_done), 32'd3);
    check("arb ibus_done", 32'(i_done), 32'd6);
    check("arb dbus_data", dbus_data, 32'h0000_1000 ^ KEY);
    check("arb ibus_data", ibus_data, 32'h0000_0010 ^ KEY);
    ibus_read = 1'b0; dbus_read = 1'b0; cpu_stall = 5'h00;
    tick();

    // Store with AW accepted on WR_REQ cycle 1 and W on cycle 3.
    aw_dly = 1; w_dly = 3;
    dbus_write = 1'b1; dbus_addr = 32'hA000_0004;
    dbus_wdata = 32'hCAFE_F00D; dbus_byteenable = 4'b0011;
    cpu_stall = 5'h1f;
    #1;
    aw_m = '0; w_m = '0; b_m = '0; n = 0;
    for (int k = 0; k < 16; k++) begin
      if (!dbus_stall) break;
      aw_m[k] = awvalid; w_m[k] = wvalid; b_m[k] = bready;
      n++;
      tick();
    end
    check("wr awvalid_cycles", 32'(aw_m), 32'h0006);
    check("wr wvalid_cycles",  32'(w_m),  32'h001E);
    check("wr bready_cycles",  32'(b_m),  32'h0020);
    check("wr stall_cycles",   32'(n),    32'd6);
    check("wr awaddr", cap_awaddr, 32'h0000_0004);
    check("wr wdata",  cap_wdata,  32'hCAFE_F00D);
    check("wr wstrb",  32'(cap_wstrb), 32'h3);
    dbus_write = 1'b0; cpu_stall = 5'h00; aw_dly = 0; w_dly = 0;
    tick();

    // Flush while RD_DATA waits on a slow rvalid: result dropped, refetch after IDLE.
    ar_log.delete();
    r_dly = 2;
    ibus_read = 1'b1; ibus_addr = 32'h8000_0020; cpu_stall = 5'h1f;
    #1;
    ar_m = '0; r_m = '0; st_m = '0;
    for (int k = 0; k < 16; k++) begin
      ar_m[k] = arvalid; r_m[k] = rready; st_m[k] = ibus_stall;
      if (k == 2) cpu_flush = 1'b1;
      if (k == 3) cpu_flush = 1'b0;
      if (k == 5) r_dly = 0;
      tick();
    end
    check("flush arvalid_cycles", 32'(ar_m), 32'h0042);
    check("flush rready_cycles",  32'(r_m),  32'h009C);
    check("flush stall_cycles",   32'(st_m), 32'h00FF);
    check("flush ar_count", 32'(ar_log.size()), 32'd2);
    check("flush ibus_data", ibus_data, 32'h0000_0020 ^ KEY);
    ibus_read = 1'b0; cpu_stall = 5'h00;
    tick();

    // IF/ID held after a completed fetch: no refetch, buffer stable.
    ibus_read = 1'b1; ibus_addr = 32'h8000_0040; cpu_stall = 5'h1f;
    #1;
    n = 0;
    while (ibus_stall && n < 20) begin n++; tick(); end
    check("hold fetch_cycles", 32'(n), 32'd3);
    cpu_stall = 5'b00010;
    n = ar_log.size();
    held = ibus_data;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("hold stall c%0d", k), 32'(ibus_stall), 32'd0);
    end
    check("hold ar_count", 32'(ar_log.size()), 32'(n));
    check("hold ibus_data", ibus_data, 32'h0000_0040 ^ KEY);
    check("hold data_stable", ibus_data, held);
    ibus_read = 1'b0; cpu_stall = 5'h00;
    tick();

    // Reset in WR_REQ: AXI valids drop at once, stalls track the raw requests.
    aw_dly = 5; w_dly = 5;
    ibus_read = 1'b1; ibus_addr = 32'h8000_0080;
    dbus_write = 1'b1; dbus_addr = 32'hA000_0008; cpu_stall = 5'h1f;
    tick();
    check("rstmid awvalid_before", 32'(awvalid), 32'd1);
    check("rstmid wvalid_before",  32'(wvalid),  32'd1);
    reset = 1'b1;
    #1;
    check("rstmid awvalid", 32'(awvalid), 32'd0);
    check("rstmid wvalid",  32'(wvalid),  32'd0);
    check("rstmid arvalid", 32'(arvalid), 32'd0);
    check("rstmid dbus_stall", 32'(dbus_stall), 32'd1);
    check("rstmid ibus_stall", 32'(ibus_stall), 32'd1);
    check("rstmid ibus_data", ibus_data, 32'h0);
    dbus_write = 1'b0; ibus_read = 1'b0;
    #1;
    check("rstmid dbus_stall_idle", 32'(dbus_stall), 32'd0);
    tick();
    reset = 1'b0; aw_dly = 0; w_dly = 0; cpu_stall = 5'h00;
    tick();
    run_read(1'b0, 32'hBFC0_0004, 32'h1FC0_0004, 3, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Sits directly downstream of the bit_mips core: consumes its ibus/dbus request ports and returns ibus_data/dbus_data plus ibus_stall/dbus_stall.
- Converts requests into single-beat AXI3/4 master transactions toward the SoC interconnect.
- One outstanding transaction at a time; dbus has priority over ibus.
- Uses the core's output_stall/output_flush to retire buffered results and discard stale ones.

Parameters:
- ID_W, 4, width of arid/awid (both driven 0).
- KSEG_XLATE, 1, 1 = map kseg0/kseg1 (addr[31:30]==2'b10) to physical {3'b000,addr[28:0]}; 0 = pass-through.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- ibus_addr  in  32  fetch address
- ibus_read  in  1  fetch request (level, held while stalled)
- ibus_data  out  32  fetched word
- ibus_stall  out  1  fetch not yet complete
- dbus_addr  in  32  data address
- dbus_read  in  1  load request
- dbus_write  in  1  store request
- dbus_wdata  in  32  store data
- dbus_byteenable  in  4  store byte lanes
- dbus_data  out  32  load word
- dbus_stall  out  1  data access not yet complete
- cpu_stall  in  5  core output_stall vector
- cpu_flush  in  1  core output_flush
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/32/8/3/2/1  read address; arlen=0, arsize=3'b010, arburst=2'b01
- arready  in  1
- rdata/rvalid/rlast  in  32/1/1
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/32/8/3/2/1  write address; same constants as AR
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1  wlast=1
- wready  in  1
- bvalid  in  1
- bready  out  1

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- Registers: src (0=ibus, 1=dbus), addr/wdata/wstrb latches, aw_done, w_done, discard, i_valid/i_buf, d_valid/d_buf.
- Reset: state=IDLE; all valid/ready outputs 0; i_valid=d_valid=discard=0; ibus_data=dbus_data=0.
- IDLE arbitration:
  - d_pend = (dbus_read|dbus_write) & ~d_valid & ~cpu_flush
  - i_pend = ibus_read & ~i_valid & ~cpu_flush
  - d_pend wins over i_pend.
  - Request accepted → latch (translated) address/data; go to RD_ADDR (reads) or WR_REQ (dbus_write).
  - dbus_read & dbus_write both set → write.
- RD_ADDR: arvalid=1, held until arready; then RD_DATA.
- RD_DATA: rready=1; on rvalid:
  - if ~discard, write rdata into i_buf/d_buf per src and set the matching valid.
  - Then IDLE. rlast ignored.
- WR_REQ:
  - awvalid and wvalid asserted together the same cycle.
  - Each drops individually after its handshake (aw_done/w_done).
  - When both done → WR_RESP.
- WR_RESP: bready=1; on bvalid set d_valid (unless discard) → IDLE. bresp ignored.
- Stall outputs (combinational):
  - ibus_stall = ibus_read & ~i_valid
  - dbus_stall = (dbus_read|dbus_write) & ~d_valid
- Data outputs: ibus_data = i_buf, dbus_data = d_buf; registered, valid the cycle after the R handshake.
- Minimum read latency: accept → AR handshake → R handshake → stall low. With arready and rvalid both at first opportunity, stall is high 3 cycles.
- Retire:
  - i_valid cleared on any edge with cpu_stall[1]==0 (IF/ID advances).
  - d_valid cleared on any edge with cpu_stall[4]==0 (MEM/WB advances).
  - Clear and set never coincide, because a valid bit is only set while the bridge is stalling that stage.
- Flush:
  - cpu_flush clears i_valid and d_valid on that edge.
  - If state≠IDLE, set discard; the AXI transaction still completes, its result is dropped, and discard is cleared on return to IDLE.
  - cpu_flush blocks acceptance in IDLE that cycle.
- Reset mid-transaction: immediate return to IDLE with all valids low. No AXI protocol preservation is required; the SoC is reset together.

Test Plan:
- Fetch from 0xBFC00000 with arready=1, rvalid one cycle after AR → araddr=0x1FC00000, ibus_stall high 3 cycles, ibus_data=rdata, i_valid cleared when cpu_stall=0.
- ibus_read and dbus_read asserted in the same cycle at 0x80000010/0x80001000 → first AR addr=0x00001000 (dbus), second 0x00000010; dbus_stall drops before ibus_stall.
- Store addr=0xA0000004, byteenable=4'b0011, awready at cycle 1, wready at cycle 3 → awvalid drops after cycle 1, wvalid after cycle 3, wstrb=0011, bready then dbus_stall low after bvalid.
- cpu_flush pulsed while in RD_DATA → transaction completes with rready, i_valid stays 0, next fetch issues only after IDLE.
- cpu_stall[1]=1 held 4 cycles after fetch completes → ibus_stall stays 0, no new AR issued, i_buf stable.
- reset asserted while in WR_REQ with awvalid=1 → awvalid/wvalid drop asynchronously, state IDLE, stalls follow the requests.
